// File: rtl/pipe_addsub.sv
// Pipelined WIDTH-bit adder/subtractor with valid/ready handshaking.
// Stage k adds operand slice k with the carry registered by stage k-1, so the
// carry chain per cycle is only SW = WIDTH/STAGES bits long.
module pipe_addsub #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned SW   = WIDTH / STAGES;
    localparam int unsigned LAST = STAGES - 1;

    // Per-stage registers: valid, operands, partial result, slice carry-out.
    logic [STAGES-1:0]            vld_q;
    logic [STAGES-1:0][WIDTH-1:0] a_q;
    logic [STAGES-1:0][WIDTH-1:0] b_q;
    logic [STAGES-1:0][WIDTH-1:0] s_q;
    logic [STAGES-1:0]            c_q;
    logic                         ovf_q;

    // Values presented to each stage (external inputs for stage 0).
    logic [STAGES-1:0]            x_v;
    logic [STAGES-1:0][WIDTH-1:0] x_a;
    logic [STAGES-1:0][WIDTH-1:0] x_b;
    logic [STAGES-1:0][WIDTH-1:0] x_s;
    logic [STAGES-1:0]            x_c;

    // Next-state values and load enables.
    logic [STAGES-1:0][SW:0]      slc;
    logic [STAGES-1:0][WIDTH-1:0] s_d;
    logic [STAGES-1:0]            adv;
    logic                         all_full;
    logic                         msb_cin;
    logic                         ovf_d;

    // A stage loads unless it and every stage after it are full and the output stalls.
    always_comb begin
        adv      = '0;
        all_full = 1'b1;
        for (int k = int'(STAGES) - 1; k >= 0; k--) begin
            all_full = all_full & vld_q[k];
            adv[k]   = out_ready | ~all_full;
        end
    end

    // Stage inputs: subtract folds into the operands as a + ~b + ~cin.
    always_comb begin
        x_v    = '0;
        x_a    = '0;
        x_b    = '0;
        x_s    = '0;
        x_c    = '0;
        x_v[0] = in_valid;
        x_a[0] = a;
        x_b[0] = sub ? ~b : b;
        x_c[0] = cin ^ sub;
        for (int k = 1; k < int'(STAGES); k++) begin
            x_v[k] = vld_q[k-1];
            x_a[k] = a_q[k-1];
            x_b[k] = b_q[k-1];
            x_s[k] = s_q[k-1];
            x_c[k] = c_q[k-1];
        end
    end

    // Slice add per stage, plus signed overflow from the final slice.
    always_comb begin
        slc = '0;
        s_d = '0;
        for (int k = 0; k < int'(STAGES); k++) begin
            slc[k] = (SW+1)'(x_a[k][k*SW +: SW]) + (SW+1)'(x_b[k][k*SW +: SW])
                   + (SW+1)'(x_c[k]);
            s_d[k] = x_s[k];
            s_d[k][k*SW +: SW] = slc[k][SW-1:0];
        end
        msb_cin = slc[LAST][SW-1] ^ x_a[LAST][WIDTH-1] ^ x_b[LAST][WIDTH-1];
        ovf_d   = msb_cin ^ slc[LAST][SW];
    end

    // Pipeline registers; reset clears valids and visible outputs immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            s_q   <= '0;
            c_q   <= '0;
            ovf_q <= 1'b0;
        end else begin
            for (int k = 0; k < int'(STAGES); k++) begin
                if (adv[k]) begin
                    vld_q[k] <= x_v[k];
                    a_q[k]   <= x_a[k];
                    b_q[k]   <= x_b[k];
                    s_q[k]   <= s_d[k];
                    c_q[k]   <= slc[k][SW];
                end
            end
            if (adv[LAST]) begin
                ovf_q <= ovf_d;
            end
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = vld_q[LAST];
    assign sum       = s_q[LAST];
    assign cout      = c_q[LAST];
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipe_addsub.sv
// Bench for pipe_addsub: directed vectors, backpressure and reset sequences on
// an 8/4 instance, plus randomized streams on 8/4, 8/1 and 16/16 instances.
module tb_pipe_addsub;

    logic clk;
    logic rst_n;
    logic rand_go;
    int   n_pass;
    int   n_tot;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Directed instance, WIDTH=8 STAGES=4
    logic       in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
    logic [7:0] a, b, sum;

    pipe_addsub #(.WIDTH(8), .STAGES(4)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] s;
        logic       c;
        logic       o;
    } vec_t;

    vec_t tbl[8];

    // Wait for out_valid starting right after the acceptance edge; returns edge count.
    task automatic wait_out(output int lat);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            if (out_valid) begin
                lat = i;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Randomized instances with their own reference model and scoreboard
    for (genvar gi = 0; gi < 3; gi++) begin : g
        localparam int unsigned W = (gi == 2) ? 16 : 8;
        localparam int unsigned S = (gi == 0) ? 4 : ((gi == 1) ? 1 : 16);

        logic         iv, ir, ci, sb, ov, ordy, co, of;
        logic [W-1:0] ra, rb, rs;
        logic [W+1:0] q[$];
        logic [W+1:0] exp;
        bit           done;
        int           n_acc;
        int           lat;

        pipe_addsub #(.WIDTH(W), .STAGES(S)) dut (
            .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir),
            .a(ra), .b(rb), .cin(ci), .sub(sb), .out_valid(ov),
            .out_ready(ordy), .sum(rs), .cout(co), .ovf(of)
        );

        // Arithmetic reference: returns {sum, cout, ovf}
        function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                               input logic c, input logic s);
            longint half, ux, uy, sx, sy, r, sr;
            logic   cy, ov_f;
            half = longint'(1) << (W - 1);
            ux   = longint'(x);
            uy   = longint'(y);
            sx   = x[W-1] ? ux - 2 * half : ux;
            sy   = y[W-1] ? uy - 2 * half : uy;
            if (s) begin
                r  = ux - uy - longint'(c);
                sr = sx - sy - longint'(c);
                cy = (r >= 0);
            end else begin
                r  = ux + uy + longint'(c);
                sr = sx + sy + longint'(c);
                cy = (r >= 2 * half);
            end
            ov_f = (sr >= half) || (sr < -half);
            return {W'(r), cy, ov_f};
        endfunction

        initial begin
            iv = 1'b0; ordy = 1'b0; ra = '0; rb = '0; ci = 1'b0; sb = 1'b0;
            done = 1'b0; n_acc = 0;
            wait (rand_go);
            for (int cyc = 0; cyc < 8000; cyc++) begin
                if (n_acc >= 1000 && q.size() == 0) break;
                @(negedge clk);
                iv   = (n_acc < 1000) && ($urandom_range(0, 3) != 0);
                ra   = W'($urandom);
                rb   = W'($urandom);
                ci   = 1'($urandom);
                sb   = 1'($urandom);
                ordy = ($urandom_range(0, 3) != 0);
                #1;
                if (iv && ir) begin
                    q.push_back(model(ra, rb, ci, sb));
                    n_acc++;
                end
                if (ov && ordy) begin
                    if (q.size() == 0) begin
                        chk($sformatf("rand%0d unexpected result", gi), 64'd1, 64'd0);
                    end else begin
                        exp = q.pop_front();
                        chk($sformatf("rand%0d result", gi), 64'({rs, co, of}), 64'(exp));
                    end
                end
            end
            chk($sformatf("rand%0d all drained", gi), 64'((n_acc == 1000) && (q.size() == 0)), 64'd1);
            // Single-transfer latency with no backpressure
            @(negedge clk);
            iv = 1'b0;
            ordy = 1'b1;
            @(negedge clk);
            iv = 1'b1; ra = W'($urandom); rb = W'($urandom); ci = 1'($urandom); sb = 1'($urandom);
            exp = model(ra, rb, ci, sb);
            #1;
            chk($sformatf("rand%0d lat in_ready", gi), 64'(ir), 64'd1);
            @(posedge clk);
            #1;
            iv  = 1'b0;
            lat = 0;
            for (int i = 1; i <= 40; i++) begin
                if (ov) begin
                    lat = i;
                    break;
                end
                @(posedge clk);
                #1;
            end
            chk($sformatf("rand%0d latency", gi), 64'(lat), 64'(S));
            chk($sformatf("rand%0d latency value", gi), 64'({rs, co, of}), 64'(exp));
            done = 1'b1;
        end
    end

    initial begin
        int         lat;
        int         sent, recv, cyc;
        bit         saw_stall_ready, was_stalled;
        logic [9:0] held;
        logic [7:0] bp_a[8];
        logic [7:0] bp_b[8];
        logic [7:0] bp_exp[8];

        n_pass = 0; n_tot = 0; rand_go = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0; sub = 1'b0;

        tbl[0] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[1] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        tbl[2] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
        tbl[3] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
        tbl[4] = '{8'h10, 8'h01, 1'b1, 1'b1, 8'h0E, 1'b1, 1'b0};
        tbl[5] = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
        tbl[6] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
        tbl[7] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};

        // Reset state
        rst_n = 1'b0;
        #3;
        chk("reset in_ready", 64'(in_ready), 64'd1);
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset outputs", 64'({sum, cout, ovf}), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors, one at a time
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            a = tbl[i].a; b = tbl[i].b; cin = tbl[i].cin; sub = tbl[i].sub;
            in_valid = 1'b1; out_ready = 1'b1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            wait_out(lat);
            chk($sformatf("vec%0d latency", i), 64'(lat), 64'd4);
            chk($sformatf("vec%0d sum", i), 64'(sum), 64'(tbl[i].s));
            chk($sformatf("vec%0d cout", i), 64'(cout), 64'(tbl[i].c));
            chk($sformatf("vec%0d ovf", i), 64'(ovf), 64'(tbl[i].o));
        end
        @(negedge clk);
        @(negedge clk);

        // Backpressure: 8 sets streamed, out_ready low during cycles 5..9
        for (int i = 0; i < 8; i++) begin
            bp_a[i]   = 8'(16 * i + 3);
            bp_b[i]   = 8'(7 * i + 32);
            bp_exp[i] = 8'(bp_a[i] + bp_b[i]);
        end
        sent = 0; recv = 0; saw_stall_ready = 1'b0; was_stalled = 1'b0; held = '0;
        cin = 1'b0; sub = 1'b0;
        for (cyc = 1; cyc <= 60 && recv < 8; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 5 && cyc <= 9);
            in_valid  = (sent < 8);
            a = (sent < 8) ? bp_a[sent] : 8'h00;
            b = (sent < 8) ? bp_b[sent] : 8'h00;
            #1;
            if (was_stalled) chk("stall hold", 64'({sum, cout, ovf}), 64'(held));
            if (in_valid && !in_ready) saw_stall_ready = 1'b1;
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) begin
                chk($sformatf("bp result%0d", recv), 64'(sum), 64'(bp_exp[recv]));
                recv++;
            end
            was_stalled = out_valid && !out_ready;
            held = {sum, cout, ovf};
        end
        chk("bp all received", 64'(recv), 64'd8);
        chk("bp in_ready fell", 64'(saw_stall_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        chk("bp empty afterwards", 64'(out_valid), 64'd0);

        // Reset mid-flight: 3 sets accepted, first one reaches output, then reset
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a = 8'(8'h11 * (i + 1)); b = 8'h22; in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("pre-reset out_valid", 64'(out_valid), 64'd1);
        chk("pre-reset sum", 64'(sum), 64'h33);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset out_valid", 64'(out_valid), 64'd0);
        chk("async reset outputs", 64'({sum, cout, ovf}), 64'd0);
        chk("async reset in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        a = 8'h40; b = 8'h15; cin = 1'b1; sub = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk("post-reset in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_out(lat);
        chk("post-reset latency", 64'(lat), 64'd4);
        chk("post-reset result", 64'({sum, cout, ovf}), 64'({8'h2A, 1'b1, 1'b0}));
        @(negedge clk);
        sub = 1'b0; cin = 1'b0;

        // Randomized streams on all three configurations
        rand_go = 1'b1;
        for (int i = 0; i < 30000; i++) begin
            if (g[0].done && g[1].done && g[2].done) break;
            @(posedge clk);
        end
        chk("random runs finished", 64'(g[0].done && g[1].done && g[2].done), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
